alu_responder: RTL and testbench



---
 rtl/alu_responder_if.sv | 28 ++
 rtl/alu_responder.sv | 105 ++++++++++
 tb/tb_alu_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_responder_if.sv
// Request/response bus of the ALU responder, including the system-level INTR/BUSY lines.
interface alu_responder_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [2:0]        REQ_OP;
  logic [TAG_W-1:0]  REQ_TAG;
  logic [DATA_W-1:0] REQ_A;
  logic [DATA_W-1:0] REQ_B;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [TAG_W-1:0]  RSP_TAG;
  logic [DATA_W-1:0] RSP_DATA;
  logic              INTR;
  logic              BUSY;

  modport master (
    output REQ_VALID, REQ_OP, REQ_TAG, REQ_A, REQ_B, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_TAG, RSP_DATA, INTR, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_TAG, REQ_A, REQ_B, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_TAG, RSP_DATA, INTR, BUSY
  );
endinterface

// File: rtl/alu_responder.sv
// ALU responder: single-cycle logic/add/shift ops, fixed-latency shift-add multiply,
// one operation in flight, result held until the consumer takes it.
module alu_responder #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic           nRST,
  input  logic           MCLK,
  alu_responder_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_acc, r_mcand, r_mplier, r_rsp_data;
  logic [DATA_W-1:0] w_alu, w_acc_nxt;
  logic [SH_W-1:0]   r_cnt;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic              r_intr, r_busy;
  logic              w_accept, w_rsp_hs;

  assign bus.REQ_READY = (r_state == S_IDLE);
  assign bus.RSP_VALID = (r_state == S_DONE);
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_TAG   = r_rsp_tag;
  assign bus.INTR      = r_intr;
  assign bus.BUSY      = r_busy;

  assign w_accept  = bus.REQ_VALID & bus.REQ_READY;
  assign w_rsp_hs  = (r_state == S_DONE) & bus.RSP_READY;
  // Partial-product add for the current multiplier bit.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle result straight from the request operands.
  always_comb begin
    w_alu = '0;
    case (bus.REQ_OP)
      OP_ADD: w_alu = bus.REQ_A + bus.REQ_B;
      OP_SUB: w_alu = bus.REQ_A - bus.REQ_B;
      OP_AND: w_alu = bus.REQ_A & bus.REQ_B;
      OP_OR:  w_alu = bus.REQ_A | bus.REQ_B;
      OP_XOR: w_alu = bus.REQ_A ^ bus.REQ_B;
      OP_SHL: w_alu = bus.REQ_A << bus.REQ_B[SH_W-1:0];
      OP_SHR: w_alu = bus.REQ_A >> bus.REQ_B[SH_W-1:0];
      default: w_alu = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (bus.REQ_OP == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: if (w_rsp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath: operand capture, multiply iterations, response and status flops.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_tag  <= '0;
      r_intr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Pulse only on entry to DONE so a stalled response does not re-interrupt.
      r_intr <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      r_busy <= (w_state_nxt != S_IDLE);
      if (r_state == S_IDLE && w_accept) begin
        r_rsp_tag <= bus.REQ_TAG;
        if (bus.REQ_OP == OP_MUL) begin
          r_acc    <= '0;
          r_mcand  <= bus.REQ_A;
          r_mplier <= bus.REQ_B;
          r_cnt    <= SH_W'(DATA_W - 1);
        end else begin
          r_rsp_data <= w_alu;
        end
      end
      // Always DATA_W iterations, no early exit, so multiply latency is constant.
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        if (r_cnt == '0) r_rsp_data <= w_acc_nxt;
        else             r_cnt      <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed cases plus random ops against an arithmetic model.
module tb_alu_responder;
  logic MCLK = 1'b0;
  logic nRST = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 MCLK = ~MCLK;

  alu_responder_if #(.DATA_W(32), .TAG_W(4)) bus ();

  alu_responder #(.DATA_W(32), .TAG_W(4)) dut (
    .nRST (nRST),
    .MCLK (MCLK),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      3'd6: return a >> (b % 32);
      default: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // Present a request and hold it until the accepting edge; returns 1 ns after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int w = 0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP = op; bus.REQ_A = a; bus.REQ_B = b; bus.REQ_TAG = tag;
    while (!bus.REQ_READY && w < 100) begin tick(); w++; end
    if (w >= 100) chk("req_ready_timeout", 0, 1);
    tick();
    bus.REQ_VALID = 1'b0;
  endtask

  // Full transaction with RSP_READY=1: latency, data, tag, INTR/BUSY, then handshake.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp, input int exp_lat);
    int lat = 1;
    int rdy_hi = 0;
    bus.RSP_READY = 1'b1;
    issue(op, a, b, tag);
    while (!bus.RSP_VALID && lat < 100) begin
      if (bus.REQ_READY) rdy_hi++;
      tick(); lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_ready_low"}, rdy_hi, 0);
    chk({name, "_data"}, bus.RSP_DATA, exp);
    chk({name, "_tag"}, bus.RSP_TAG, tag);
    chk({name, "_intr"}, bus.INTR, 1);
    chk({name, "_busy"}, bus.BUSY, 1);
    tick();
    chk({name, "_valid_drop"}, bus.RSP_VALID, 0);
    chk({name, "_intr_drop"}, bus.INTR, 0);
    chk({name, "_busy_drop"}, bus.BUSY, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, d0;
    logic [3:0]  tg;
    logic [31:0] q_d[$];
    logic [3:0]  q_t[$];
    int n_acc, n_rsp, cyc, last_acc, intr_cnt;
    bit acc_now;

    bus.REQ_VALID = 0; bus.REQ_OP = 0; bus.REQ_A = 0; bus.REQ_B = 0; bus.REQ_TAG = 0;
    bus.RSP_READY = 0;

    // Reset state, with a request offered during reset.
    bus.REQ_VALID = 1'b1; bus.REQ_OP = 3'd0; bus.REQ_A = 32'h5; bus.REQ_B = 32'h6;
    repeat (3) tick();
    chk("rst_req_ready", bus.REQ_READY, 1);
    chk("rst_rsp_valid", bus.RSP_VALID, 0);
    chk("rst_rsp_data", bus.RSP_DATA, 0);
    chk("rst_rsp_tag", bus.RSP_TAG, 0);
    chk("rst_intr", bus.INTR, 0);
    chk("rst_busy", bus.BUSY, 0);
    bus.REQ_VALID = 1'b0;
    @(negedge MCLK); nRST = 1'b1;
    tick();

    // Directed single-cycle ops.
    do_op("add", 3'd0, 32'hFFFF_FFFF, 32'h2, 4'd3, 32'h0000_0001, 1);
    do_op("sub", 3'd1, 32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE, 1);
    do_op("shl", 3'd5, 32'h1, 32'h21, 4'd2, 32'h0000_0002, 1);
    do_op("shr", 3'd6, 32'h8000_0000, 32'd31, 4'd4, 32'h0000_0001, 1);
    do_op("shr32", 3'd6, 32'h1234_5678, 32'd32, 4'd5, 32'h1234_5678, 1);
    do_op("or", 3'd3, 32'hF000_000F, 32'h0F00_00F0, 4'd6, 32'hFF00_00FF, 1);

    // Directed multiplies.
    do_op("mul", 3'd7, 32'h0001_0003, 32'h0000_0005, 4'd9, 32'h0005_000F, 33);
    do_op("mul_ones", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'h0000_0001, 33);
    do_op("mul_zero", 3'd7, 32'h0, 32'hDEAD_BEEF, 4'd11, 32'h0, 33);

    // Random ops of every opcode against the model.
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; tg = 4'($urandom);
      do_op("rand", op, a, b, tg, model(op, a, b), (op == 3'd7) ? 33 : 1);
    end

    // Stalled response: held data, single INTR, requests blocked.
    bus.RSP_READY = 1'b0;
    issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7);
    chk("stall_first_valid", bus.RSP_VALID, 1);
    bus.REQ_VALID = 1'b1; bus.REQ_OP = 3'd0; bus.REQ_A = 32'h1; bus.REQ_B = 32'h1; bus.REQ_TAG = 4'd15;
    intr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", bus.RSP_VALID, 1);
      chk("stall_data", bus.RSP_DATA, 32'hF000_F000);
      chk("stall_tag", bus.RSP_TAG, 4'd7);
      chk("stall_req_ready", bus.REQ_READY, 0);
      intr_cnt += int'(bus.INTR);
      tick();
    end
    chk("stall_intr_count", intr_cnt, 1);
    chk("stall_still_valid", bus.RSP_VALID, 1);
    bus.REQ_VALID = 1'b0; bus.RSP_READY = 1'b1;
    tick();
    chk("stall_hs_valid", bus.RSP_VALID, 0);
    chk("stall_data_kept", bus.RSP_DATA, 32'hF000_F000);
    tick();
    chk("stall_idle_busy", bus.BUSY, 0);
    chk("stall_idle_ready", bus.REQ_READY, 1);

    // Streaming single-cycle ops with REQ_VALID/RSP_READY held high.
    n_acc = 0; n_rsp = 0; cyc = 0; last_acc = -1;
    bus.RSP_READY = 1'b1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP = 3'($urandom_range(0, 6)); bus.REQ_A = $urandom; bus.REQ_B = $urandom; bus.REQ_TAG = 4'($urandom);
    while (n_rsp < 16 && cyc < 200) begin
      acc_now = bus.REQ_VALID && bus.REQ_READY;
      if (bus.RSP_VALID) begin
        if (q_d.size() == 0) chk("stream_unexpected_rsp", 1, 0);
        else begin
          chk("stream_data", bus.RSP_DATA, q_d.pop_front());
          chk("stream_tag", bus.RSP_TAG, q_t.pop_front());
        end
        n_rsp++;
      end
      op = bus.REQ_OP; a = bus.REQ_A; b = bus.REQ_B; tg = bus.REQ_TAG;
      tick(); cyc++;
      if (acc_now) begin
        q_d.push_back(model(op, a, b));
        q_t.push_back(tg);
        if (last_acc >= 0) chk("stream_gap", cyc - last_acc, 2);
        last_acc = cyc;
        n_acc++;
        if (n_acc < 16) begin
          bus.REQ_OP = 3'($urandom_range(0, 6)); bus.REQ_A = $urandom; bus.REQ_B = $urandom;
          bus.REQ_TAG = 4'($urandom);
        end else bus.REQ_VALID = 1'b0;
      end
    end
    chk("stream_rsp_count", n_rsp, 16);
    chk("stream_acc_count", n_acc, 16);
    tick();

    // Reset during a multiply.
    d0 = $urandom;
    issue(3'd7, d0, 32'h3, 4'd12);
    repeat (9) tick();
    chk("mul_midway_busy", bus.BUSY, 1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_rsp_valid", bus.RSP_VALID, 0);
    chk("arst_intr", bus.INTR, 0);
    chk("arst_busy", bus.BUSY, 0);
    chk("arst_req_ready", bus.REQ_READY, 1);
    bus.REQ_VALID = 1'b1; bus.REQ_OP = 3'd1;
    repeat (3) tick();
    chk("arst_hold_busy", bus.BUSY, 0);
    chk("arst_hold_valid", bus.RSP_VALID, 0);
    bus.REQ_VALID = 1'b0;
    @(negedge MCLK); nRST = 1'b1;
    tick();
    chk("post_rst_ready", bus.REQ_READY, 1);
    chk("post_rst_intr", bus.INTR, 0);
    do_op("xor", 3'd4, 32'hAAAA_5555, 32'hFFFF_0000, 4'd8, 32'h5555_5555, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
